// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the five-stage datapath and hazard_controller.
// The datapath (master) drives stage register indices and control bits;
// the controller (slave) returns stall/flush/forward controls, the memory
// timeout flag and the performance counters.
interface hazard_controller_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  logic        RegWriteM;
  logic        RegWriteW;
  logic        MemReqM;
  logic        MemReadyM;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        MemErr;
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    output RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr, StallCycles, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    input  RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward sequencer for the five-stage core.
// Detects load-use and taken-branch hazards, freezes the whole pipeline while
// a data-memory access waits on MemReadyM, and latches a sticky error if the
// wait exceeds TIMEOUT_CYCLES (1..255).
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// StallCycles / FlushCount performance counters; otherwise both read 0.
module hazard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic [7:0] w_wait_cnt_inc;
  logic       w_lw_stall;
  logic       w_mem_wait;
  logic       w_freeze;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_w;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Forward select for one E-stage source: M result beats W result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       rw_m,
    input logic [4:0] rd_m,
    input logic       rw_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs_e
  );
    logic [1:0] sel;
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign w_mem_wait = hz.MemReqM && !hz.MemReadyM;

  // Wait counter saturates at 255 so it can never wrap back below the limit.
  assign w_wait_cnt_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : (r_wait_cnt + 8'd1);

  // Next-state / wait-counter logic and freeze decision.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_freeze       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_freeze       = 1'b1;
          w_wait_cnt_nxt = 8'd1;
          if (TIMEOUT_LIM <= 8'd1) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_wait_cnt_nxt = 8'd0;
        end
      end
      ST_WAIT: begin
        if (w_mem_wait) begin
          w_freeze       = 1'b1;
          w_wait_cnt_nxt = w_wait_cnt_inc;
          if (w_wait_cnt_inc >= TIMEOUT_LIM) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          // Access completed (or withdrawn): release in this same cycle.
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = 8'd0;
        end
      end
      ST_ERROR: begin
        w_freeze    = 1'b1;
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Stall/flush/forward outputs; all forced idle while reset is asserted.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    w_fwd_a   = 2'b00;
    w_fwd_b   = 2'b00;
    if (!rst) begin
      w_stall_f = 1'b0;
    end else begin
      w_fwd_a = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
      w_fwd_b = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);
      if (w_freeze) begin
        // Full freeze: hold every stage, bubble into M/W, ignore branch and load-use.
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else begin
        w_stall_f = w_lw_stall;
        w_stall_d = w_lw_stall;
        w_flush_d = hz.PCSrcE;
        w_flush_e = w_lw_stall || hz.PCSrcE;
      end
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  assign hz.StallF    = w_stall_f;
  assign hz.StallD    = w_stall_d;
  assign hz.StallE    = w_stall_e;
  assign hz.StallM    = w_stall_m;
  assign hz.FlushD    = w_flush_d;
  assign hz.FlushE    = w_flush_e;
  assign hz.FlushW    = w_flush_w;
  assign hz.ForwardAE = w_fwd_a;
  assign hz.ForwardBE = w_fwd_b;
  assign hz.MemErr    = (r_state == ST_ERROR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Saturating counts of StallF cycles and FlushE cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (w_stall_f && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (w_flush_e && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign hz.StallCycles = r_stall_cycles;
  assign hz.FlushCount  = r_flush_count;
`else
  assign hz.StallCycles = 32'd0;
  assign hz.FlushCount  = 32'd0;
`endif

endmodule
